// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state codes,
// instruction field layout and small decode helpers.
package instr_fetch_pkg;

    localparam int INSTR_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_ISSUE = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_DONE  = 3'd4;
    localparam state_t S_ERR   = 3'd5;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int OPA_HI = 11;
    localparam int OPA_LO = 8;
    localparam int OPB_HI = 7;
    localparam int OPB_LO = 4;
    localparam int OPC_HI = 3;
    localparam int OPC_LO = 0;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    // The sequencer owns the processor handshake in these states.
    function automatic logic is_busy(input state_t s);
        logic b;
        case (s)
            S_FETCH, S_ISSUE, S_WAIT: b = 1'b1;
            default:                  b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// Program store: one synchronous write port, one combinational
// read port; a same-cycle write to the read address is forwarded.
module instr_mem
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               CLK,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Write-first read port.
    always_comb begin
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem_r[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program sequencer: steps through the instruction memory and runs the
// START/RDY handshake with the downstream processor for each word.
module instr_fetch_unit
    import instr_fetch_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               RDY,
    output logic [INSTR_W-1:0] Instr,
    output logic               START,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PC_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PC_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_n;
    logic [INSTR_W-1:0]   instr_r;
    logic                 start_r;
    logic [AW-1:0]        pc_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic [CW-1:0]        cnt_r;

    logic [INSTR_W-1:0]   mem_rdata_s;
    logic                 mem_we_s;
    logic                 halt_s;
    logic                 cnt_last_s;
    logic                 pc_last_s;

    assign mem_we_s   = load_en & ~busy_r;
    assign halt_s     = (opcode_of(mem_rdata_s) == HALT_OP);
    assign cnt_last_s = (cnt_r == CNT_MAX);
    assign pc_last_s  = (pc_r == PC_LAST);

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we_s),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_r),
        .rdata (mem_rdata_s)
    );

    // Next-state decode; FETCH never issues while the processor is busy.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (run) state_n = S_FETCH;
                else     state_n = state_r;
            end
            S_FETCH: begin
                if (!RDY)        state_n = S_FETCH;
                else if (halt_s) state_n = S_DONE;
                else             state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (!RDY)            state_n = S_WAIT;
                else if (cnt_last_s) state_n = S_ERR;
                else                 state_n = S_ISSUE;
            end
            S_WAIT: begin
                if (!RDY)           state_n = S_WAIT;
                else if (pc_last_s) state_n = S_DONE;
                else                state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and its registered busy decode.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= is_busy(state_n);
        end
    end

    // Datapath: pc, issued word, handshake request, timeout and status flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instr_r <= {INSTR_W{1'b0}};
            start_r <= 1'b0;
            pc_r    <= PC_ZERO;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (run) begin
                        pc_r   <= PC_ZERO;
                        done_r <= 1'b0;
                        err_r  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (RDY) begin
                        if (halt_s) begin
                            done_r <= 1'b1;
                        end else begin
                            instr_r <= mem_rdata_s;
                            start_r <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!RDY) begin
                        start_r <= 1'b0;
                    end else if (cnt_last_s) begin
                        start_r <= 1'b0;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    // The last word ends the program without wrapping pc.
                    if (RDY) begin
                        if (pc_last_s) done_r <= 1'b1;
                        else           pc_r   <= pc_r + PC_ONE;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                end
            endcase
        end
    end

    assign Instr = instr_r;
    assign START = start_r;
    assign pc    = pc_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a cycle-level processor
// model and a program-level reference model of the sequencer.
module tb_instr_fetch_unit;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        run = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [15:0] load_data = 16'd0;
    logic        RDY;
    logic [15:0] Instr;
    logic        START;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    logic proc_rdy;
    logic hold_low  = 1'b0;
    logic proc_dead = 1'b0;
    int   proc_cnt;
    int   cyc = 0;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          off_q[$];
    int          start_hi;

    typedef struct {
        int         halt_at;
        int         exp_issues;
        logic [3:0] exp_pc;
    } vec_t;
    vec_t tbl [5];

    assign RDY = proc_rdy & ~hold_low;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Processor: accepts START while halted, drops RDY one edge later,
    // raises it again four edges after that.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            proc_rdy <= 1'b1;
            proc_cnt <= 0;
        end else if (proc_cnt == 0) begin
            if (START && proc_rdy && !proc_dead) proc_cnt <= 1;
        end else if (proc_cnt == 1) begin
            proc_rdy <= 1'b0;
            proc_cnt <= 2;
        end else if (proc_cnt < 5) begin
            proc_cnt <= proc_cnt + 1;
        end else begin
            proc_rdy <= 1'b1;
            proc_cnt <= 0;
        end
    end

    instr_fetch_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .run       (run),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .RDY       (RDY),
        .Instr     (Instr),
        .START     (START),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        model_mem[a] = d;
        @(negedge CLK);
        load_en = 1'b0;
    endtask

    // Reference: walk the program until a HALT word or the last address.
    task automatic model_run(output logic [3:0] fpc);
        int  p;
        bit  stop;
        exp_q.delete();
        p = 0;
        stop = 1'b0;
        fpc = 4'd0;
        while (!stop) begin
            if (model_mem[p][15:12] == 4'hF) begin
                fpc = 4'(p);
                stop = 1'b1;
            end else begin
                exp_q.push_back(model_mem[p]);
                if (p == DEPTH - 1) begin
                    fpc = 4'(p);
                    stop = 1'b1;
                end else begin
                    p++;
                end
            end
        end
    endtask

    task automatic pulse_run(output int r);
        r = cyc;
        run = 1'b1;
        @(negedge CLK);
        run = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, " idle timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic run_collect(input string tag, input int budget);
        int r;
        int n;
        bit prev;
        bit finished;
        got_q.delete();
        off_q.delete();
        start_hi = 0;
        pulse_run(r);
        chk({tag, " err cleared by run"}, 32'(err), 32'd0);
        chk({tag, " done cleared by run"}, 32'(done), 32'd0);
        prev = 1'b0;
        finished = 1'b0;
        n = 0;
        while (n < budget && !finished) begin
            if (START && !prev) begin
                got_q.push_back(Instr);
                off_q.push_back(cyc - r);
            end
            if (START) start_hi++;
            prev = START;
            if (done || err) begin
                finished = 1'b1;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        chk({tag, " run completed"}, 32'(finished), 32'd1);
    endtask

    task automatic compare_program(input string tag);
        logic [3:0] fpc;
        model_run(fpc);
        chk({tag, " issue count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            chk($sformatf("%s instr[%0d]", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
            chk($sformatf("%s start offset[%0d]", tag, k), 32'(off_q[k]), 32'(2 + 8 * k));
        end
        chk({tag, " final pc"}, 32'(pc), 32'(fpc));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_plain(input int halt_at);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == halt_at) load_word(i, 16'hF000 | 16'(i));
            else load_word(i, {4'((i % 14) + 1), 4'(i), 4'(~i), 4'(i + 3)});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        int falls;
        bit prev;
        bit seen;

        tbl[0] = '{halt_at: 0,  exp_issues: 0,  exp_pc: 4'd0};
        tbl[1] = '{halt_at: 1,  exp_issues: 1,  exp_pc: 4'd1};
        tbl[2] = '{halt_at: 3,  exp_issues: 3,  exp_pc: 4'd3};
        tbl[3] = '{halt_at: 15, exp_issues: 15, exp_pc: 4'd15};
        tbl[4] = '{halt_at: 16, exp_issues: 16, exp_pc: 4'd15};

        #12;
        chk("reset Instr", 32'(Instr), 32'd0);
        chk("reset START", 32'(START), 32'd0);
        chk("reset pc", 32'(pc), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Basic three-word program ending in HALT.
        load_word(0, 16'h1123);
        load_word(1, 16'h2456);
        load_word(2, 16'hF000);
        run_collect("basic", 100);
        chk("basic START count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            chk("basic first Instr", 32'(got_q[0]), 32'h1123);
            chk("basic second Instr", 32'(got_q[1]), 32'h2456);
            chk("basic first START at", 32'(off_q[0]), 32'd2);
            chk("basic second START at", 32'(off_q[1]), 32'd10);
        end
        chk("basic pc", 32'(pc), 32'd2);
        chk("basic done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("basic no third START", 32'(START), 32'd0);
        end

        // Table of HALT placements including none and the last address.
        for (int v = 0; v < 5; v++) begin
            fill_plain(tbl[v].halt_at);
            run_collect($sformatf("tbl%0d", v), 200);
            chk($sformatf("tbl%0d issues", v), 32'(got_q.size()), 32'(tbl[v].exp_issues));
            chk($sformatf("tbl%0d pc", v), 32'(pc), 32'(tbl[v].exp_pc));
            compare_program($sformatf("tbl%0d", v));
        end

        // Processor never accepts: handshake timeout.
        proc_dead = 1'b1;
        run_collect("timeout", 60);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout done", 32'(done), 32'd0);
        chk("timeout START width", 32'(start_hi), 32'(TIMEOUT + 1));
        chk("timeout START low", 32'(START), 32'd0);
        chk("timeout busy", 32'(busy), 32'd0);
        @(negedge CLK);
        chk("timeout err held", 32'(err), 32'd1);
        proc_dead = 1'b0;
        run_collect("after timeout", 200);
        compare_program("after timeout");

        // Loads while busy must be ignored.
        fill_plain(5);
        pulse_run(r);
        chk("wp busy", 32'(busy), 32'd1);
        load_en = 1'b1;
        load_addr = 4'd0;
        load_data = 16'hFFFF;
        for (int i = 0; i < 6; i++) @(negedge CLK);
        load_en = 1'b0;
        wait_idle("wp", 200);
        run_collect("wp rerun", 200);
        compare_program("wp rerun");

        // Asynchronous reset during WAIT of the second instruction.
        fill_plain(16);
        pulse_run(r);
        falls = 0;
        prev = 1'b0;
        n = 0;
        while (falls < 2 && n < 40) begin
            if (prev && !START) falls++;
            prev = START;
            if (falls < 2) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("rst reached WAIT", 32'(falls), 32'd2);
        chk("rst pc before", 32'(pc), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("rst START", 32'(START), 32'd0);
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        fill_plain(4);
        run_collect("rst rerun", 200);
        compare_program("rst rerun");

        // Processor busy while FETCH: no issue until RDY returns.
        hold_low = 1'b1;
        pulse_run(r);
        for (int i = 0; i < 5; i++) begin
            chk("hold no START", 32'(START), 32'd0);
            @(negedge CLK);
        end
        hold_low = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 4) begin
            @(negedge CLK);
            n++;
            if (START) seen = 1'b1;
        end
        chk("hold START after release", 32'(seen), 32'd1);
        chk("hold Instr", 32'(Instr), 32'(model_mem[0]));
        wait_idle("hold", 200);
        chk("hold done pc", 32'(pc), 32'd4);

        // Random programs against the reference model.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 14));
                if ($urandom_range(0, 9) == 0) op = 4'hF;
                load_word(a, {op, 12'($urandom)});
            end
            run_collect($sformatf("rand%0d", it), 200);
            compare_program($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
